// File: rtl/commit_history.sv
// commit_history
//   Ring buffer of the most recently committed PCs, fed by up to LANES commit
//   lanes per cycle. It also keeps the youngest committed PC and a running
//   retired-instruction count.
//
// Ports
//   clk             sole clock; all state updates on its rising edge
//   rst_n           asynchronous active-low reset
//   i_commit_valid  per-lane commit valid (lane 0 is oldest)
//   i_commit_flush  per-lane bubble marker; a flushed lane is ignored
//   i_commit_pc     per-lane committed PC
//   i_clear         synchronous history clear
//   i_freeze        holds ring contents and pointers (debug)
//   i_rd_idx        history read index, 0 = youngest entry
//   o_last_pc       PC of the youngest accepted commit
//   o_rd_pc         PC at i_rd_idx (0 when the entry is not populated)
//   o_rd_valid      i_rd_idx addresses a populated entry
//   o_count         populated entries, saturating at DEPTH
//   o_overflow      sticky: an entry was overwritten since reset/clear
//   o_instret       total accepted commits since reset
module commit_history #(
    parameter int          LANES    = 2,
    parameter int          DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    localparam int         AW       = $clog2(DEPTH),
    localparam int         CW       = AW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES-1:0]       i_commit_valid,
    input  logic [LANES-1:0]       i_commit_flush,
    input  logic [LANES-1:0][63:0] i_commit_pc,
    input  logic                   i_clear,
    input  logic                   i_freeze,
    input  logic [AW-1:0]          i_rd_idx,
    output logic [63:0]            o_last_pc,
    output logic [63:0]            o_rd_pc,
    output logic                   o_rd_valid,
    output logic [CW-1:0]          o_count,
    output logic                   o_overflow,
    output logic [63:0]            o_instret
);

    // Accepted-lane count needs to hold values up to 4.
    localparam int KW = 3;

    logic [AW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic [63:0]            r_last_pc;
    logic [63:0]            r_instret;
    logic [63:0]            r_ring [DEPTH];

    logic [LANES-1:0]          w_acc;
    logic [LANES-1:0][AW-1:0]  w_slot;
    logic [KW-1:0]             w_k;
    logic [63:0]               w_last_pc_next;
    logic [CW:0]               w_sum;
    logic                      w_over;
    logic                      w_ring_we;
    logic [AW-1:0]             w_rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_acc
            assign w_acc[gi] = i_commit_valid[gi] & ~i_commit_flush[gi];
        end
    endgenerate

    // Compaction: each accepted lane lands at wr_ptr plus the number of
    // accepted lanes below it, so flushed lanes leave no hole. The slot
    // arithmetic wraps naturally at AW bits, which handles a write that
    // straddles entry DEPTH-1 and entry 0 in the same cycle.
    always_comb begin
        w_k            = '0;
        w_last_pc_next = r_last_pc;
        for (int j = 0; j < LANES; j++) begin
            w_slot[j] = r_wr_ptr + AW'(w_k);
            if (w_acc[j]) begin
                w_k            = w_k + KW'(1);
                w_last_pc_next = i_commit_pc[j];
            end
        end
    end

    assign w_sum     = (CW+1)'(r_count) + (CW+1)'(w_k);
    assign w_over    = w_sum > (CW+1)'(DEPTH);
    // clear takes priority over freeze; both block ring writes.
    assign w_ring_we = ~i_clear & ~i_freeze;

    // Ring storage carries no reset: its contents are masked by count.
    always_ff @(posedge clk) begin
        if (w_ring_we) begin
            for (int j = 0; j < LANES; j++) begin
                if (w_acc[j]) begin
                    r_ring[w_slot[j]] <= i_commit_pc[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_last_pc  <= RESET_PC;
            r_instret  <= '0;
        end else begin
            // last_pc and instret keep tracking commits through clear/freeze.
            r_last_pc <= w_last_pc_next;
            r_instret <= r_instret + 64'(w_k);
            if (i_clear) begin
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (!i_freeze) begin
                r_wr_ptr <= r_wr_ptr + AW'(w_k);
                r_count  <= w_over ? CW'(DEPTH) : w_sum[CW-1:0];
                if (w_over) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Index 0 is the entry just behind the write pointer (youngest).
    assign w_rd_addr  = r_wr_ptr - AW'(1) - i_rd_idx;
    assign o_rd_valid = {1'b0, i_rd_idx} < r_count;
    assign o_rd_pc    = o_rd_valid ? r_ring[w_rd_addr] : 64'd0;

    assign o_last_pc  = r_last_pc;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_instret  = r_instret;

endmodule

// File: tb/tb_commit_history.sv
// Testbench for commit_history (LANES=2, DEPTH=8). A queue-based model holds
// the history youngest-first; a negedge process compares every output and
// every read index against it each cycle. Directed sequences pin the model
// with hand-computed literals, then randomized traffic follows.
module tb_commit_history;

    localparam int          LANES    = 2;
    localparam int          DEPTH    = 8;
    localparam int          AW       = 3;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [LANES-1:0]       commit_valid = '0;
    logic [LANES-1:0]       commit_flush = '0;
    logic [LANES-1:0][63:0] commit_pc = '0;
    logic                   clear = 1'b0;
    logic                   freeze = 1'b0;
    logic [AW-1:0]          rd_idx = '0;
    logic [63:0]            last_pc;
    logic [63:0]            rd_pc;
    logic                   rd_valid;
    logic [AW:0]            count;
    logic                   overflow;
    logic [63:0]            instret;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference model: hist[0] is the youngest entry.
    logic [63:0] hist[$];
    logic [63:0] m_last_pc;
    logic [63:0] m_instret;
    logic        m_ovf;

    commit_history #(
        .LANES(LANES), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_commit_valid(commit_valid), .i_commit_flush(commit_flush),
        .i_commit_pc(commit_pc), .i_clear(clear), .i_freeze(freeze),
        .i_rd_idx(rd_idx),
        .o_last_pc(last_pc), .o_rd_pc(rd_pc), .o_rd_valid(rd_valid),
        .o_count(count), .o_overflow(overflow), .o_instret(instret)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_last_pc = RESET_PC;
        m_instret = 64'd0;
        m_ovf     = 1'b0;
    endtask

    // Apply one clock edge's worth of inputs to the model.
    task automatic model_edge();
        logic [63:0] acc[$];
        for (int j = 0; j < LANES; j++)
            if (commit_valid[j] && !commit_flush[j]) acc.push_back(commit_pc[j]);
        if (acc.size() > 0) m_last_pc = acc[acc.size()-1];
        m_instret = m_instret + 64'(acc.size());
        if (clear) begin
            hist.delete();
            m_ovf = 1'b0;
        end else if (!freeze) begin
            foreach (acc[j]) begin
                hist.push_front(acc[j]);
                if (hist.size() > DEPTH) begin
                    void'(hist.pop_back());
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Per-cycle compare: scalar outputs plus a sweep over all read indices.
    always @(negedge clk) begin
        if (check_en) begin
            chk("last_pc", last_pc, m_last_pc);
            chk("instret", instret, m_instret);
            chk("count", 64'(count), 64'(hist.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            for (int i = 0; i < DEPTH; i++) begin
                rd_idx = AW'(i);
                #1;
                chk($sformatf("rd_valid[%0d]", i), 64'(rd_valid), 64'(i < hist.size()));
                chk($sformatf("rd_pc[%0d]", i), rd_pc, (i < hist.size()) ? hist[i] : 64'd0);
            end
        end
    end

    // Drive one cycle of inputs from posedge+1, update model at the edge.
    task automatic cyc(input logic [1:0] v, input logic [1:0] f,
                       input logic [63:0] p0, input logic [63:0] p1,
                       input logic clr, input logic frz);
        commit_valid = v;
        commit_flush = f;
        commit_pc[0] = p0;
        commit_pc[1] = p1;
        clear        = clr;
        freeze       = frz;
        @(posedge clk);
        model_edge();
        #1;
        $display("txn t=%0t v=%b f=%b clr=%b frz=%b -> last_pc=%h count=%0d ovf=%b instret=%0d",
                 $time, v, f, clr, frz, last_pc, count, overflow, instret);
        commit_valid = '0;
        commit_flush = '0;
        clear        = 1'b0;
        freeze       = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; outputs checked while held.
    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_last_pc", last_pc, RESET_PC);
        chk("rst_instret", instret, 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_pc", rd_pc, 64'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  v;
        logic [1:0]  f;
        logic [63:0] p0;
        logic [63:0] p1;
        logic        clr;
        logic        frz;

        model_reset();
        reset_pulse();
        check_en = 1'b1;

        // Lane 1 flushed: only lane 0 is accepted.
        cyc(2'b11, 2'b10, 64'h8000_0004, 64'h0000_dead, 1'b0, 1'b0);
        chk("d1_last_pc", last_pc, 64'h8000_0004);
        chk("d1_count", 64'(count), 64'd1);
        chk("d1_instret", instret, 64'd1);
        chk("d1_model_size", 64'(hist.size()), 64'd1);
        chk("d1_model_h0", hist[0], 64'h8000_0004);

        // Lane 0 flushed, lane 1 written with no hole.
        cyc(2'b11, 2'b01, 64'h0000_1111, 64'h200, 1'b0, 1'b0);
        chk("d2_last_pc", last_pc, 64'h200);
        chk("d2_count", 64'(count), 64'd2);
        chk("d2_model_h0", hist[0], 64'h200);
        chk("d2_model_h1", hist[1], 64'h8000_0004);

        // Freeze: ring/count hold, last_pc and instret track.
        cyc(2'b01, 2'b00, 64'h300, 64'h0, 1'b0, 1'b1);
        chk("d3_last_pc", last_pc, 64'h300);
        chk("d3_count", 64'(count), 64'd2);
        chk("d3_instret", instret, 64'd3);
        chk("d3_model_h0", hist[0], 64'h200);

        cyc(2'b01, 2'b00, 64'h304, 64'h0, 1'b0, 1'b0);
        chk("d4_count", 64'(count), 64'd3);
        chk("d4_model_h0", hist[0], 64'h304);
        chk("d4_model_h1", hist[1], 64'h200);

        // Clear with a simultaneous commit.
        cyc(2'b01, 2'b00, 64'h400, 64'h0, 1'b1, 1'b0);
        chk("d5_count", 64'(count), 64'd0);
        chk("d5_overflow", 64'(overflow), 64'd0);
        chk("d5_last_pc", last_pc, 64'h400);
        chk("d5_instret", instret, 64'd5);

        // Clear beats freeze.
        cyc(2'b01, 2'b00, 64'h404, 64'h0, 1'b0, 1'b0);
        cyc(2'b00, 2'b00, 64'h0, 64'h0, 1'b1, 1'b1);
        chk("d6_count", 64'(count), 64'd0);
        chk("d6_instret", instret, 64'd6);

        // Mid-stream reset, then first commit lands at index 0.
        reset_pulse();
        cyc(2'b01, 2'b00, 64'h500, 64'h0, 1'b0, 1'b0);
        chk("d7_count", 64'(count), 64'd1);
        chk("d7_instret", instret, 64'd1);
        chk("d7_model_h0", hist[0], 64'h500);

        // Five dual commits into an 8-entry ring: saturation and overflow.
        reset_pulse();
        for (int i = 0; i < 5; i++)
            cyc(2'b11, 2'b00, 64'h100 + 64'(8*i), 64'h104 + 64'(8*i), 1'b0, 1'b0);
        chk("d8_count", 64'(count), 64'd8);
        chk("d8_overflow", 64'(overflow), 64'd1);
        chk("d8_instret", instret, 64'd10);
        chk("d8_model_h0", hist[0], 64'h124);
        chk("d8_model_h7", hist[7], 64'h108);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            v   = 2'($urandom);
            f   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            p0  = {$urandom, $urandom};
            p1  = {$urandom, $urandom};
            clr = ($urandom_range(0, 24) == 0);
            frz = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) reset_pulse();
            else cyc(v, f, p0, p1, clr, frz);
        end

        @(posedge clk);
        #12;
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
